// File: rtl/time_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : time_count_ctrl
//  Purpose  : Run-control sequencer for an mm:ss time counter. Owns the 1 s
//             prescaler and the seconds/minutes registers and sequences them
//             through IDLE / RUN / PAUSE / ALARM. Counts up (stopwatch) or
//             down (timer with preset, alarm at 00:00).
//  Ports    : InClk        system clock
//             InReset      asynchronous reset, active-low
//             InStart      pulse: start / resume (mode sampled from InDown)
//             InStop       pulse: pause
//             InClear      pulse: abort to IDLE, value 00:00
//             InLoad       pulse: load preset (IDLE/PAUSE, or ALARM -> IDLE)
//             InDown       level: 1 = count down, 0 = count up
//             InPresetSec  preset seconds (saturated to 59)
//             InPresetMin  preset minutes (saturated to 59)
//             OutSecond    current seconds 0..59
//             OutMinute    current minutes 0..59
//             OutRunning   high in RUN
//             OutTick      one-cycle pulse on the cycle the value updates
//             OutAlarm     high in ALARM
//             (TIMER_LAP_EN) InLap, OutLapSec, OutLapMin, OutLapValid
//  Options  : define TIMER_LAP_EN to add the lap-capture registers and ports.
//  Revision : 1.0  initial release
// ============================================================================
module time_count_ctrl #(
  parameter int TICK_DIV = 1_000_000,
  parameter int CNT_W    = 20
) (
  input  logic       InClk,
  input  logic       InReset,
  input  logic       InStart,
  input  logic       InStop,
  input  logic       InClear,
  input  logic       InLoad,
  input  logic       InDown,
  input  logic [5:0] InPresetSec,
  input  logic [5:0] InPresetMin,
  output logic [5:0] OutSecond,
  output logic [5:0] OutMinute,
  output logic       OutRunning,
  output logic       OutTick,
  output logic       OutAlarm
`ifdef TIMER_LAP_EN
  ,
  input  logic       InLap,
  output logic [5:0] OutLapSec,
  output logic [5:0] OutLapMin,
  output logic       OutLapValid
`endif
);

  localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0]       c_MAX_FIELD = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_presc;
  logic [5:0]       r_sec;
  logic [5:0]       r_min;
  logic             r_down;
  logic             r_tick;
  logic             r_running;
  logic             r_alarm;

  // Values after the run/tick phase, before commands are applied.
  state_t           w_state_t;
  logic [CNT_W-1:0] w_presc_t;
  logic [5:0]       w_sec_t;
  logic [5:0]       w_min_t;
  logic             w_tick;
  logic             w_to_alarm;

  // Final next-state values after commands.
  state_t           w_state_n;
  logic [CNT_W-1:0] w_presc_n;
  logic [5:0]       w_sec_n;
  logic [5:0]       w_min_n;
  logic             w_down_n;

  logic [5:0]       w_pre_sec;
  logic [5:0]       w_pre_min;

  assign w_pre_sec = (InPresetSec > c_MAX_FIELD) ? c_MAX_FIELD : InPresetSec;
  assign w_pre_min = (InPresetMin > c_MAX_FIELD) ? c_MAX_FIELD : InPresetMin;

  // Run phase. A down-count sitting at 00:00 in RUN moves to ALARM one cycle
  // after the value reached zero (this also covers starting down at 00:00),
  // and no further tick is generated so the minutes never underflow.
  always_comb begin
    w_to_alarm = (r_state == ST_RUN) && r_down && (r_sec == 6'd0) && (r_min == 6'd0);
    w_tick     = (r_state == ST_RUN) && !w_to_alarm && (r_presc == c_TICK_LAST);
    w_state_t  = w_to_alarm ? ST_ALARM : r_state;
    w_presc_t  = r_presc;
    w_sec_t    = r_sec;
    w_min_t    = r_min;

    if ((r_state == ST_RUN) && !w_to_alarm) begin
      w_presc_t = w_tick ? '0 : (r_presc + CNT_W'(1));
    end

    if (w_tick) begin
      if (!r_down) begin
        if (r_sec == c_MAX_FIELD) begin
          w_sec_t = 6'd0;
          w_min_t = (r_min == c_MAX_FIELD) ? 6'd0 : (r_min + 6'd1);
        end else begin
          w_sec_t = r_sec + 6'd1;
        end
      end else begin
        if (r_sec == 6'd0) begin
          w_sec_t = c_MAX_FIELD;
          w_min_t = r_min - 6'd1;
        end else begin
          w_sec_t = r_sec - 6'd1;
        end
      end
    end
  end

  // Command phase: exactly one command (highest priority asserted) is
  // considered, and it acts on the post-tick state and value.
  always_comb begin
    w_state_n = w_state_t;
    w_presc_n = w_presc_t;
    w_sec_n   = w_sec_t;
    w_min_n   = w_min_t;
    w_down_n  = r_down;

    if (InClear) begin
      w_state_n = ST_IDLE;
      w_presc_n = '0;
      w_sec_n   = 6'd0;
      w_min_n   = 6'd0;
    end else if (InLoad) begin
      if (w_state_t != ST_RUN) begin
        w_sec_n   = w_pre_sec;
        w_min_n   = w_pre_min;
        w_presc_n = '0;
        w_state_n = (w_state_t == ST_ALARM) ? ST_IDLE : w_state_t;
      end
    end else if (InStop) begin
      if (w_state_t == ST_RUN) begin
        w_state_n = ST_PAUSE;
      end
    end else if (InStart) begin
      if ((w_state_t == ST_IDLE) || (w_state_t == ST_PAUSE)) begin
        w_state_n = ST_RUN;
        w_down_n  = InDown;
        // Resuming from PAUSE keeps the partial second.
        if (w_state_t == ST_IDLE) begin
          w_presc_n = '0;
        end
      end
    end
  end

  always_ff @(posedge InClk or negedge InReset) begin
    if (!InReset) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_sec     <= 6'd0;
      r_min     <= 6'd0;
      r_down    <= 1'b0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_presc   <= w_presc_n;
      r_sec     <= w_sec_n;
      r_min     <= w_min_n;
      r_down    <= w_down_n;
      r_tick    <= w_tick;
      r_running <= (w_state_n == ST_RUN);
      r_alarm   <= (w_state_n == ST_ALARM);
    end
  end

  assign OutSecond  = r_sec;
  assign OutMinute  = r_min;
  assign OutRunning = r_running;
  assign OutTick    = r_tick;
  assign OutAlarm   = r_alarm;

`ifdef TIMER_LAP_EN
  logic [5:0] r_lap_sec;
  logic [5:0] r_lap_min;
  logic       r_lap_valid;

  // Lap captures the post-tick value; it never touches the live count.
  always_ff @(posedge InClk or negedge InReset) begin
    if (!InReset) begin
      r_lap_sec   <= 6'd0;
      r_lap_min   <= 6'd0;
      r_lap_valid <= 1'b0;
    end else if (InClear) begin
      r_lap_sec   <= 6'd0;
      r_lap_min   <= 6'd0;
      r_lap_valid <= 1'b0;
    end else if (InLap && (w_state_t == ST_RUN)) begin
      r_lap_sec   <= w_sec_t;
      r_lap_min   <= w_min_t;
      r_lap_valid <= 1'b1;
    end
  end

  assign OutLapSec   = r_lap_sec;
  assign OutLapMin   = r_lap_min;
  assign OutLapValid = r_lap_valid;
`endif

endmodule
`default_nettype wire
